cbus_rr_arbiter: RTL and testbench

CBUS_RR_ARBITER -- requirements
Module: cbus_rr_arbiter

---
 rtl/cbus_rr_arbiter.sv | 114 +++++++++++
 tb/tb_cbus_rr_arbiter.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/cbus_rr_arbiter.sv
// Round-robin arbiter that funnels several upstream cbus masters onto one
// memory-side cbus. One grant is held for a whole burst; a burst ends only
// when the memory side returns ready together with last.

package cbus_pkg;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [3:0]  strobe;
    logic [31:0] data;
    logic [7:0]  len;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [31:0] data;
  } cbus_resp_t;

endpackage

module cbus_rr_arbiter
  import cbus_pkg::*;
#(
  parameter int unsigned NUM_INPUTS = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  cbus_req_t  ireqs  [NUM_INPUTS],
  output cbus_resp_t iresps [NUM_INPUTS],
  output cbus_req_t  oreq,
  input  cbus_resp_t oresp
);

  localparam int unsigned SelW = $clog2(NUM_INPUTS);

  typedef enum logic {StIdle, StBusy} state_e;

  state_e          r_state;
  logic [SelW-1:0] r_sel;
  logic [SelW-1:0] r_rr_ptr;

  logic            w_found;
  logic [SelW-1:0] w_pick;
  logic [SelW-1:0] w_ptr_next;
  logic            w_done;

  // Pick the first valid master at or after the round-robin pointer. The scan
  // runs from the farthest offset down so the nearest valid one wins.
  always_comb begin
    w_found = 1'b0;
    w_pick  = r_rr_ptr;
    for (int k = int'(NUM_INPUTS) - 1; k >= 0; k--) begin
      logic [SelW-1:0] idx;
      idx = SelW'((32'(r_rr_ptr) + 32'(k)) % NUM_INPUTS);
      if (ireqs[idx].valid) begin
        w_found = 1'b1;
        w_pick  = idx;
      end
    end
  end

  // Pointer advances to the master after the one just served.
  always_comb begin
    if (r_sel == SelW'(NUM_INPUTS - 1)) begin
      w_ptr_next = '0;
    end else begin
      w_ptr_next = r_sel + SelW'(1);
    end
    w_done = oresp.ready & oresp.last;
  end

  // Grant FSM: latch the winner on entry to BUSY, hold it until the last beat.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= StIdle;
      r_sel    <= '0;
      r_rr_ptr <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (w_found) begin
            r_sel   <= w_pick;
            r_state <= StBusy;
          end
        end
        StBusy: begin
          if (w_done) begin
            r_state  <= StIdle;
            r_rr_ptr <= w_ptr_next;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // Live pass-through of the granted master; everything zero otherwise. The
  // reset term keeps outputs quiet for the whole time reset is held.
  always_comb begin
    oreq = '0;
    for (int i = 0; i < int'(NUM_INPUTS); i++) begin
      iresps[i] = '0;
    end
    if (r_state == StBusy && !reset) begin
      oreq          = ireqs[r_sel];
      iresps[r_sel] = oresp;
    end
  end

endmodule

// File: tb/tb_cbus_rr_arbiter.sv
// Scoreboard bench for cbus_rr_arbiter with two masters. Stimulus pushes one
// expected record per granted beat; the monitor pops on every cycle where
// oreq.valid is high and checks all-zero outputs on every other cycle.

module tb_cbus_rr_arbiter;
  import cbus_pkg::*;

  localparam int N = 2;

  typedef struct {
    int         cyc;
    int         port;
    cbus_req_t  req;
    cbus_resp_t resp;
  } beat_t;

  logic       clk = 1'b0;
  logic       reset;
  cbus_req_t  ireqs  [N];
  cbus_resp_t iresps [N];
  cbus_req_t  oreq;
  cbus_resp_t oresp;

  beat_t sb[$];
  int    cyc      = 0;
  int    n_checks = 0;
  int    n_fail   = 0;

  cbus_rr_arbiter #(
    .NUM_INPUTS(N)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .ireqs (ireqs),
    .iresps(iresps),
    .oreq  (oreq),
    .oresp (oresp)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: sampled mid-cycle, away from the rising edge.
  always @(negedge clk) begin : mon
    beat_t      e;
    cbus_resp_t exp_r;
    logic       ok;
    if (oreq.valid) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL grant_unexpected: cyc=%0d oreq=%h, required no grant", cyc, oreq);
      end else begin
        e  = sb.pop_front();
        ok = (cyc == e.cyc) && (oreq == e.req);
        for (int i = 0; i < N; i++) begin
          exp_r = '0;
          if (i == e.port) exp_r = e.resp;
          if (iresps[i] != exp_r) ok = 1'b0;
        end
        if (!ok) begin
          n_fail++;
          $display("FAIL beat_port%0d: cyc=%0d oreq=%h iresps0=%h iresps1=%h, required cyc=%0d oreq=%h resp=%h",
                   e.port, cyc, oreq, iresps[0], iresps[1], e.cyc, e.req, e.resp);
        end
      end
    end else begin
      n_checks++;
      if (oreq != '0 || iresps[0] != '0 || iresps[1] != '0) begin
        n_fail++;
        $display("FAIL idle_zero: cyc=%0d oreq=%h iresps0=%h iresps1=%h, required all zero",
                 cyc, oreq, iresps[0], iresps[1]);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic cbus_req_t mk_req(input logic wr, input logic [31:0] addr,
                                       input logic [7:0] len);
    cbus_req_t r;
    r          = '0;
    r.valid    = 1'b1;
    r.is_write = wr;
    r.size     = 3'd2;
    r.addr     = addr;
    r.strobe   = wr ? 4'hF : 4'h0;
    r.len      = len;
    return r;
  endfunction

  // Called in an IDLE cycle where port p is the expected winner. Drives
  // nbeats ready beats (last on the final one) and returns in the IDLE cycle
  // that follows. Optionally raises the other port's valid at intrude_beat.
  task automatic run_burst(input int p, input int nbeats, input int intrude_beat,
                           input logic [31:0] wd0, input logic [31:0] wd1);
    beat_t e;
    step();
    for (int b = 0; b < nbeats; b++) begin
      if (b == intrude_beat) ireqs[1-p] = mk_req(1'b0, 32'h8000_2000, 8'd0);
      if (ireqs[p].is_write) ireqs[p].data = (b == 0) ? wd0 : wd1;
      oresp.ready = 1'b1;
      oresp.last  = (b == nbeats - 1);
      oresp.data  = 32'hC0DE_0000 + 32'(p * 256 + b);
      e.cyc  = cyc;
      e.port = p;
      e.req  = ireqs[p];
      e.resp = oresp;
      sb.push_back(e);
      step();
    end
    oresp = '0;
  endtask

  initial begin : stim
    beat_t e;
    // Reset held with both masters requesting and the memory side responding.
    reset    = 1'b1;
    ireqs[0] = mk_req(1'b0, 32'h8000_0000, 8'd1);
    ireqs[1] = mk_req(1'b0, 32'h8000_1000, 8'd1);
    oresp    = '{ready: 1'b1, last: 1'b1, data: 32'hFFFF_FFFF};
    repeat (3) step();
    oresp = '0;
    reset = 1'b0;

    // Simultaneous requests after reset: port 0 first, then port 1.
    run_burst(0, 2, -1, 32'h0, 32'h0);
    ireqs[0] = '0;
    run_burst(1, 2, -1, 32'h0, 32'h0);
    ireqs[1] = '0;
    step();

    // Single 4-beat read on port 1.
    ireqs[1] = mk_req(1'b0, 32'h8000_1000, 8'd3);
    run_burst(1, 4, -1, 32'h0, 32'h0);
    ireqs[1] = '0;
    step();

    // Both masters requesting continuously: 0,1,0,1,0,1.
    ireqs[0] = mk_req(1'b0, 32'h8000_0100, 8'd0);
    ireqs[1] = mk_req(1'b0, 32'h8000_1100, 8'd0);
    for (int i = 0; i < 6; i++) run_burst(i % 2, 1, -1, 32'h0, 32'h0);
    ireqs[0] = '0;
    ireqs[1] = '0;
    step();

    // Write pass-through with per-beat data.
    ireqs[1] = mk_req(1'b1, 32'h8000_1200, 8'd1);
    run_burst(1, 2, -1, 32'hDEAD_BEEF, 32'h1234_5678);
    ireqs[1] = '0;
    step();

    // Port 0 raises valid during port 1's burst; served right after.
    ireqs[1] = mk_req(1'b0, 32'h8000_1300, 8'd3);
    run_burst(1, 4, 1, 32'h0, 32'h0);
    ireqs[1] = '0;
    run_burst(0, 1, -1, 32'h0, 32'h0);
    ireqs[0] = '0;
    step();

    // Reset on beat 2 of 4, then port 1 re-requests.
    ireqs[1] = mk_req(1'b0, 32'h8000_1400, 8'd3);
    step();
    oresp  = '{ready: 1'b1, last: 1'b0, data: 32'hB0B0_0000};
    e.cyc  = cyc;
    e.port = 1;
    e.req  = ireqs[1];
    e.resp = oresp;
    sb.push_back(e);
    step();
    reset      = 1'b1;
    oresp.data = 32'hB0B0_0001;
    step();
    step();
    reset = 1'b0;
    oresp = '0;
    run_burst(1, 4, -1, 32'h0, 32'h0);
    ireqs[1] = '0;
    step();
    step();

    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: %0d beats never granted, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
